// File: rtl/mux_nway_reg.sv
// N-way W-bit registered selector with valid/ready on every port.
// Define MUX_RR_EN to add the round-robin arbiter (mode=1); otherwise fixed select only.
module mux_nway_reg #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             load_en;
    logic             xfer;
    logic             fix_vld;
    logic [SEL_W-1:0] fix_idx;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;

    assign load_en = !out_valid_q || out_ready;

    // Loop compare keeps an out-of-range sel from ever granting.
    always_comb begin
        fix_vld = 1'b0;
        fix_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_vld = 1'b1;
                fix_idx = SEL_W'(i);
            end
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                rr_vld;
    logic [SEL_W-1:0]    rr_idx;
    logic [SEL_W:0]      rr_sum;
    logic [2*NUM_IN-1:0] rr_vv;

    // Rotate the doubled valid vector so bit 0 is the channel at ptr.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        rr_sum = '0;
        rr_vv  = {in_valid, in_valid} >> ptr_q;
        for (int k = 0; k < NUM_IN; k++) begin
            rr_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (rr_sum >= (SEL_W+1)'(NUM_IN))
                rr_sum = rr_sum - (SEL_W+1)'(NUM_IN);
            if (!rr_vld && rr_vv[k]) begin
                rr_vld = 1'b1;
                rr_idx = rr_sum[SEL_W-1:0];
            end
        end
    end

    assign grant_vld = mode ? rr_vld : fix_vld;
    assign grant_idx = mode ? rr_idx : fix_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer)
            ptr_d = (grant_idx == SEL_W'(NUM_IN-1)) ? '0 : grant_idx + SEL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign grant_vld   = fix_vld;
    assign grant_idx   = fix_idx;
`endif

    assign xfer = load_en && grant_vld && !reset;

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/mux_nway_reg.md
# mux_nway_reg

Parametrised N-way, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the 2-way 32-bit datapath select into a single-stage buffered selector. The selector either follows an external select or arbitrates round-robin among valid inputs. It sits between multiple producers (e.g. writeback sources, bus masters) and one consumer in the processor datapath.

## Interface
- NUM_IN, default 4: number of input channels, 2..16.
- WIDTH, default 32: data width per channel.
- SEL_W, default $clog2(NUM_IN): select/index width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready (combinational).
- sel  in  SEL_W  channel select, used in fixed mode.
- mode  in  1  0 = fixed select; 1 = round-robin (requires MUX_RR_EN).
- out_data  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts.

## Operation
- Reset values: out_valid=0, out_data=0, out_src=0, RR pointer ptr=0. in_ready=0 while reset is high.
- load_en = !out_valid || out_ready. Output register loads only when load_en=1 and a grant exists.
- Fixed mode:
  - grant = sel when sel < NUM_IN and in_valid[sel]=1.
  - sel >= NUM_IN produces no grant and all in_ready=0.
- Round-robin mode: scan indices ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1 (wrap-around). The first valid index is granted.
- Pointer update: after a transfer from channel g, ptr <= (g+1) mod NUM_IN. With no transfer, ptr holds.
- in_ready[i] = load_en && (i == grant) && !reset. At most one bit is set. The transfer on channel i is in_valid[i] && in_ready[i].
- On transfer: out_data <= channel g data, out_src <= g, out_valid <= 1.
- Output drain without a new transfer: out_valid <= 0; out_data and out_src hold their last values.
- Output stall (out_valid && !out_ready): out_data and out_src stay stable, and all in_ready=0.
- Mode or sel changes take effect on the grant of the same cycle. Held output is unaffected. ptr is retained across mode switches.
- Reset mid-transfer: the in-flight output is discarded and the accepted input is lost. Producers re-send.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer/cycle with out_ready held high. A simultaneous drain and load in one cycle is legal.
- No combinational path from in_data to out_data.
- Combinational paths to in_ready: in_valid/sel/mode/out_ready -> in_ready.

## Configuration
- MUX_RR_EN defined: round-robin arbiter and ptr register are compiled in, and mode selects between the two behaviours.
- MUX_RR_EN undefined: no ptr or arbiter logic; mode is ignored and the block always operates in fixed mode.

## Test plan
- Reset: assert reset with in_valid=4'hF -> out_valid=0, out_data=0, out_src=0, in_ready=0. After release, ptr=0.
- Fixed select: mode=0, sel=2, ch2=32'hDEADBEEF valid, out_ready=1 -> next cycle out_data=DEADBEEF, out_src=2. in_ready only ever 4'b0100.
- Stall: out_ready=0 for 3 cycles with ch1 valid -> out_data stays stable, in_ready=0. Raise out_ready -> ch1 transfers the same cycle and out_data updates next cycle.
- Round-robin fairness (MUX_RR_EN): all 4 channels valid, out_ready=1 -> out_src sequence 0,1,2,3,0. Then only ch3 and ch0 valid with ptr=1 -> grant 3, then 0 (wrap).
- Out-of-range select: NUM_IN=3, sel=3, all channels valid -> in_ready=0 and out_valid stays 0.
- Reset mid-stream: assert reset while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async), then RR restarts at channel 0.
